lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 41 ++++
 rtl/lsu.sv | 135 +++++++++++++
 tb/tb_lsu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state type
// and the request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Stores only have SB/SH/SW; loads additionally allow LBU/LHU.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic store);
    if (store) return f3[2] || (f3[1:0] == 2'b11);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data shift and write mask, load lane extract and
// sign/zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata_sh,
  output logic [3:0]      wmask,
  output logic [XLEN-1:0] rdata_ext
);

  logic [7:0]      mask_wide;
  logic [XLEN-1:0] rsh;

  always_comb begin
    wdata_sh  = wdata << (8 * addr_lo);
    mask_wide = 8'h00;
    case (funct3[1:0])
      2'b00:   mask_wide = 8'b0000_0001 << addr_lo;
      2'b01:   mask_wide = 8'b0000_0011 << addr_lo;
      default: mask_wide = 8'b0000_1111;
    endcase
    // Lanes pushed past byte 3 by a misaligned access are dropped.
    wmask = mask_wide[3:0];

    rsh = rdata >> (8 * addr_lo);
    case (funct3)
      F3_LB:   rdata_ext = {{(XLEN-8){rsh[7]}}, rsh[7:0]};
      F3_LH:   rdata_ext = {{(XLEN-16){rsh[15]}}, rsh[15:0]};
      F3_LBU:  rdata_ext = {{(XLEN-8){1'b0}}, rsh[7:0]};
      F3_LHU:  rdata_ext = {{(XLEN-16){1'b0}}, rsh[15:0]};
      default: rdata_ext = rsh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE -> REQ -> WAIT -> RESP handshake to data memory.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned half/word accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [2:0]      in_funct3,
  input  logic            in_store,
  output logic            mem_req,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_resp,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [2:0]      f3_q, f3_d;
  logic            store_q, store_d;
  logic            fault_q, fault_d;
  logic            early_fault;

  logic [XLEN-1:0] wdata_sh, rdata_ext;
  logic [3:0]      wmask;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (f3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (rdata_q),
    .wdata_sh  (wdata_sh),
    .wmask     (wmask),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
`ifdef LSU_MISALIGN_CHECK_EN
    early_fault = f3_illegal(in_funct3, in_store) || f3_misaligned(in_funct3, in_addr[1:0]);
`else
    early_fault = f3_illegal(in_funct3, in_store);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    store_d = store_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        addr_d  = in_addr;
        wdata_d = in_wdata;
        f3_d    = in_funct3;
        store_d = in_store;
        rdata_d = '0;
        cnt_d   = '0;
        fault_d = early_fault;
        state_d = early_fault ? S_RESP : S_REQ;
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      // A response on the final counted cycle still wins over the timeout.
      S_WAIT: begin
        if (mem_resp) begin
          rdata_d = mem_rdata;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: if (out_ready) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      store_q <= store_d;
      fault_q <= fault_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_REQ);
  assign mem_wen   = mem_req & store_q;
  assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata = store_q ? wdata_sh : '0;
  assign mem_wmask = {4'b0000, (store_q ? wmask : 4'b0000)};
  assign out_valid = (state_q == S_RESP);
  assign out_fault = out_valid & fault_q;
  assign out_rdata = (out_valid && !store_q && !fault_q) ? rdata_ext : '0;

endmodule

// File: tb/tb_lsu.sv
// Randomized and directed checks of lsu against a byte-level reference model.
module tb_lsu;

  localparam int XLEN = 32;
  localparam int TO   = 12;
`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MIS_CHK = 1'b1;
`else
  localparam bit MIS_CHK = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_addr = '0;
  logic [XLEN-1:0] in_wdata = '0;
  logic [2:0]      in_funct3 = '0;
  logic            in_store = 1'b0;
  logic            mem_req, mem_wen;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [7:0]      mem_wmask;
  logic            mem_resp = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_rdata;
  logic            out_fault;

  lsu #(.XLEN(XLEN), .TIMEOUT(TO)) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_funct3(in_funct3), .in_store(in_store),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_fault(out_fault)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // ---- reference model: byte-lane arithmetic straight from the ISA rules
  function automatic bit m_fault(input bit st, input bit [2:0] f3, input bit [1:0] a);
    bit ill, mis;
    ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    mis = (f3[1:0] == 2'd1 && a % 2 == 1) || (f3[1:0] == 2'd2 && a != 0);
    return ill || (MIS_CHK && mis);
  endfunction

  function automatic bit [31:0] m_mask(input bit [2:0] f3, input bit [1:0] a);
    int sz;
    sz = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    if (sz == 4) return 32'hF;
    return ((((1 << sz) - 1) << a) & 15);
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [1:0] a, input bit [31:0] r);
    bit [31:0] v;
    v = r >> (8 * a);
    case (f3)
      3'd0: return ((v & 255) >= 128) ? ((v & 255) | 32'hFFFF_FF00) : (v & 255);
      3'd1: return ((v & 65535) >= 32768) ? ((v & 65535) | 32'hFFFF_0000) : (v & 65535);
      3'd4: return v & 255;
      3'd5: return v & 65535;
      default: return v;
    endcase
  endfunction

  // One full transaction: accept, memory handshake after dly cycles, stall in RESP.
  task automatic run(input bit st, input bit [2:0] f3, input bit [31:0] addr,
                     input bit [31:0] wd, input bit [31:0] rd, input int dly, input int stall);
    bit        flt;
    bit [31:0] exp_rd;
    flt    = m_fault(st, f3, addr[1:0]);
    exp_rd = (st || flt) ? 32'h0 : m_load(f3, addr[1:0], rd);
    @(negedge clock);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_store = st; in_funct3 = f3; in_addr = addr; in_wdata = wd;
    @(negedge clock);
    in_valid = 0; in_addr = $urandom; in_wdata = $urandom;
    if (flt) begin
      chk("fault_skips_req", mem_req, 0);
      chk("fault_direct_resp", out_valid, 1);
    end else begin
      chk("req_latency", mem_req, 1);
      chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      chk("mem_wen", mem_wen, st);
      chk("mem_wmask", mem_wmask, st ? m_mask(f3, addr[1:0]) : 32'h0);
      if (st) chk("mem_wdata", mem_wdata, wd << (8 * addr[1:0]));
      for (int i = 0; i < dly; i++) begin
        @(negedge clock);
        if (i == 0) chk("req_one_pulse", mem_req, 0);
      end
      chk("no_early_valid", out_valid, 0);
      mem_resp = 1; mem_rdata = rd;
      @(negedge clock);
      mem_resp = 0; mem_rdata = $urandom;
      chk("resp_latency", out_valid, 1);
    end
    chk("out_fault", out_fault, flt);
    chk("out_rdata", out_rdata, exp_rd);
    chk("in_ready_busy", in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      mem_resp = 1; mem_rdata = $urandom;
      @(negedge clock);
      chk("stall_valid", out_valid, 1);
      chk("stall_rdata", out_rdata, exp_rd);
      chk("stall_in_ready", in_ready, 0);
    end
    mem_resp = 0;
    out_ready = 1;
    @(negedge clock);
    out_ready = 0;
    chk("back_idle_valid", out_valid, 0);
    chk("back_idle_ready", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit        st;
    bit [2:0]  f3;
    bit [31:0] a;
    int        k;

    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_fault", out_fault, 0);
    chk("rst_out_rdata", out_rdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // Directed examples
    run(1, 3'd0, 32'h8000_0002, 32'h0000_00AB, 32'h0, 1, 0);
    run(0, 3'd0, 32'h0000_1001, 32'h0, 32'h1234_80FF, 1, 0);
    run(0, 3'd4, 32'h0000_1001, 32'h0, 32'h1234_80FF, 2, 0);
    run(0, 3'd1, 32'h0000_2002, 32'h0, 32'h8001_0000, 10, 0);
    run(0, 3'd2, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 1, 5);
    run(0, 3'd3, 32'h0000_0000, 32'h0, 32'h1, 1, 0);
    run(0, 3'd6, 32'h0000_0000, 32'h0, 32'h1, 1, 0);
    run(0, 3'd7, 32'h0000_0000, 32'h0, 32'h1, 1, 2);
    run(1, 3'd4, 32'h0000_0000, 32'h5, 32'h1, 1, 0);
    run(1, 3'd1, 32'h0000_0003, 32'h0000_BEEF, 32'h0, 3, 0);

    // Timeout: no response ever arrives
    @(negedge clock);
    in_valid = 1; in_store = 0; in_funct3 = 3'd2; in_addr = 32'h40; in_wdata = 0;
    @(negedge clock);
    in_valid = 0;
    chk("to_req", mem_req, 1);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge clock);
      if (out_valid) k = i;
    end
    chk("to_latency", k, TO + 1);
    chk("to_fault", out_fault, 1);
    chk("to_rdata", out_rdata, 0);
    out_ready = 1; @(negedge clock); out_ready = 0;
    chk("to_idle", in_ready, 1);

    // Reset while waiting on memory, then a stale response
    in_valid = 1; in_store = 0; in_funct3 = 3'd2; in_addr = 32'h80; in_wdata = 0;
    @(negedge clock);
    in_valid = 0;
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("rstw_in_ready", in_ready, 1);
    mem_resp = 1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    mem_resp = 0;
    chk("stale_out_valid", out_valid, 0);
    chk("stale_in_ready", in_ready, 1);
    chk("stale_mem_req", mem_req, 0);
    run(0, 3'd2, 32'h0000_0102, 32'h0, 32'h0, 1, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      st = $urandom_range(0, 1);
      f3 = $urandom_range(0, 7);
      a  = $urandom;
      if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      run(st, f3, a, $urandom, $urandom, $urandom_range(1, TO), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
